// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch (imem) and load/store (dmem) ports.
// dmem has fixed priority; a starvation counter forces an imem grant after a dmem burst.
module mem_port_arbiter #(
    parameter int ADDRW          = 32,
    parameter int XLEN           = 32,
    parameter int MASKW          = 4,
    parameter int DMEM_BURST_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             imem_valid_i,
    input  logic [ADDRW-1:0] imem_addr_i,
    output logic             imem_ready_o,
    output logic             imem_rvalid_o,
    output logic [XLEN-1:0]  imem_rdata_o,
    input  logic             dmem_valid_i,
    input  logic [ADDRW-1:0] dmem_addr_i,
    input  logic [MASKW-1:0] dmem_mask_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    input  logic             dmem_we_i,
    output logic             dmem_ready_o,
    output logic             dmem_rvalid_o,
    output logic [XLEN-1:0]  dmem_rdata_o,
    output logic             bus_valid_o,
    output logic [ADDRW-1:0] bus_addr_o,
    output logic [MASKW-1:0] bus_mask_o,
    output logic [XLEN-1:0]  bus_wdata_o,
    output logic             bus_we_o,
    input  logic             bus_ready_i,
    input  logic             bus_rvalid_i,
    input  logic [XLEN-1:0]  bus_rdata_i
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam int SW = $clog2(DMEM_BURST_MAX + 1);

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [MASKW-1:0] mask;
        logic [XLEN-1:0]  wdata;
        logic             we;
    } bus_req_t;

    logic [1:0]    state;
    logic          owner_imem;
    logic [SW-1:0] starve_cnt;
    logic          imem_forced, grant_dmem, grant_imem;
    logic          active, sel_imem, accept, rsp;
    bus_req_t      imem_req, dmem_req, bus_req;

    assign imem_req = '{addr: imem_addr_i, mask: {MASKW{1'b1}}, wdata: '0, we: 1'b0};
    assign dmem_req = '{addr: dmem_addr_i, mask: dmem_mask_i, wdata: dmem_wdata_i, we: dmem_we_i};

    always_comb begin
        imem_forced = imem_valid_i && (starve_cnt == SW'(DMEM_BURST_MAX));
        grant_dmem  = dmem_valid_i && !imem_forced;
        grant_imem  = imem_valid_i && !grant_dmem;
        active      = 1'b0;
        sel_imem    = owner_imem;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    active   = grant_dmem || grant_imem;
                    sel_imem = grant_imem;
                end
                // Latched owner is held until the bus takes it, whatever else arrives.
                REQ:     active = 1'b1;
                default: active = 1'b0;
            endcase
        end
        accept = active && bus_ready_i;
        rsp    = !rst_i && (state == WAIT_RSP) && bus_rvalid_i;
    end

    assign bus_req       = active ? (sel_imem ? imem_req : dmem_req) : '0;
    assign bus_valid_o   = active;
    assign bus_addr_o    = bus_req.addr;
    assign bus_mask_o    = bus_req.mask;
    assign bus_wdata_o   = bus_req.wdata;
    assign bus_we_o      = bus_req.we;
    assign imem_ready_o  = accept && sel_imem;
    assign dmem_ready_o  = accept && !sel_imem;
    assign imem_rvalid_o = rsp && owner_imem;
    assign dmem_rvalid_o = rsp && !owner_imem;
    assign imem_rdata_o  = imem_rvalid_o ? bus_rdata_i : '0;
    assign dmem_rdata_o  = dmem_rvalid_o ? bus_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner_imem <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (active) begin
                    owner_imem <= sel_imem;
                    state      <= accept ? WAIT_RSP : REQ;
                end
                REQ:      if (accept) state <= WAIT_RSP;
                WAIT_RSP: if (bus_rvalid_i) state <= IDLE;
                default:  state <= IDLE;
            endcase
            if (accept) begin
                if (sel_imem || !imem_valid_i)
                    starve_cnt <= '0;
                else if (starve_cnt != SW'(DMEM_BURST_MAX))
                    starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule
